mc_controller: RTL and testbench

Multi-cycle sequencer for the RV32I core; replaces single-cycle control with one FSM that drives the shared-ALU datapath (one memory port, instruction register, old-PC/ALUOut/Data latches).
Decodes op/funct fields and steps each instruction through fetch, decode, execute, memory and writeback states.
Stalls on a memory ready handshake and traps illegal opcodes.

---
 rtl/mc_ctrl_pkg.sv | 67 ++++++
 rtl/mc_controller_if.sv | 42 ++++
 rtl/mc_controller_alu_decoder.sv | 38 +++
 rtl/mc_controller.sv | 227 ++++++++++++++++++++++
 tb/tb_mc_controller.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I controller (mc_controller).
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_HALT,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_JAL,
    S_TRAP
  } state_t;

  // Opcodes (Instr[6:0]) the sequencer understands.
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // ALUControl encodings.
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_SLL = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1000;

  // Coarse ALU operation class handed from the FSM to the ALU decoder.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Datapath mux encodings.
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ImmSrc: J-format (2'b11) exists in the datapath but the sequencer never selects it.
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  // States that hold a memory access open until mem_ready.
  function automatic logic is_wait_state(state_t s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Control bus between mc_controller (master) and the multi-cycle datapath (slave).
//
// Memory handshake: while the controller sits in FETCH, MEMREAD or MEMWRITE the
// access request is valid and is held unchanged (MemWrite stays high for stores);
// mem_ready is the memory's ready. The transfer happens in the cycle where the
// request is valid and mem_ready=1, and the controller moves on at that edge.
interface mc_controller_if;
  import mc_ctrl_pkg::*;

  logic       start;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       mem_ready;

  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic [3:0] ALUControl;
  logic       illegal_instr;
  logic       mem_err;
  state_t     state;

  modport master (
    input  start, op, funct3, funct7b5, Zero, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal_instr, mem_err, state
  );

  modport slave (
    output start, op, funct3, funct7b5, Zero, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal_instr, mem_err, state
  );
endinterface

// File: rtl/mc_controller_alu_decoder.sv
// ALU decoder: maps the FSM's ALU op class plus funct fields to ALUControl.
// funct3=011 (SLTU slot) is not supported and is flagged illegal.
module alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  input  logic [1:0] alu_op,
  output logic [3:0] alu_control,
  output logic       illegal
);

  // Funct decode; SUB only for R-type (op5=1) so addi with imm[10]=1 stays ADD.
  always_comb begin
    alu_control = ALU_ADD;
    illegal     = 1'b0;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000: alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001: alu_control = ALU_SLL;
          3'b010: alu_control = ALU_SLT;
          3'b011: illegal     = 1'b1;
          3'b100: alu_control = ALU_XOR;
          3'b101: alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110: alu_control = ALU_OR;
          3'b111: alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle RV32I sequencer driving a shared-ALU datapath with one memory port.
// Optional performance counters (cycle_cnt, instret_cnt) are built when
// MC_CTRL_PERF_EN is defined.
module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter int RESET_STATE_FETCH = 1,
  parameter int MEM_TIMEOUT       = 0
) (
  input  logic                clk,
  input  logic                reset,
  mc_controller_if.master     bus
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [31:0]         cycle_cnt,
  output logic [31:0]         instret_cnt
`endif
);

  localparam state_t      RESET_STATE  = (RESET_STATE_FETCH != 0) ? S_FETCH : S_HALT;
  localparam logic [31:0] TIMEOUT_LAST = 32'(MEM_TIMEOUT - 1);
  localparam logic        TIMEOUT_ON   = (MEM_TIMEOUT > 0);

  state_t      state;
  logic [31:0] wait_cnt;
  logic        illegal_q;
  logic        mem_err_q;
  logic        timeout_hit;

  logic [1:0]  alu_op;
  logic [3:0]  dec_ctrl;
  logic        dec_illegal;

  logic        pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0]  result_src, alu_src_a, alu_src_b, imm_src;
  logic [3:0]  alu_control;

  // ALU op class per state; DECODE asks for the funct decode only to screen funct3.
  always_comb begin
    alu_op = ALUOP_ADD;
    case (state)
      S_DECODE, S_EXECR, S_EXECI: alu_op = ALUOP_FUNCT;
      S_BEQ:                      alu_op = ALUOP_SUB;
      default:                    alu_op = ALUOP_ADD;
    endcase
  end

  alu_decoder u_alu_dec (
    .funct3      (bus.funct3),
    .funct7b5    (bus.funct7b5),
    .op5         (bus.op[5]),
    .alu_op      (alu_op),
    .alu_control (dec_ctrl),
    .illegal     (dec_illegal)
  );

  // Memory wait has run out on this cycle (last allowed cycle without mem_ready).
  always_comb begin
    timeout_hit = TIMEOUT_ON && is_wait_state(state) && !bus.mem_ready &&
                  (wait_cnt == TIMEOUT_LAST);
  end

  // Sequencer state, wait counter and sticky error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RESET_STATE;
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
      mem_err_q <= 1'b0;
    end else if (timeout_hit) begin
      state     <= S_TRAP;
      wait_cnt  <= '0;
      mem_err_q <= 1'b1;
    end else begin
      // Counter only advances while an access is stalled; any state change clears it.
      if (TIMEOUT_ON && is_wait_state(state) && !bus.mem_ready) begin
        wait_cnt <= wait_cnt + 32'd1;
      end else begin
        wait_cnt <= '0;
      end

      case (state)
        S_HALT:   if (bus.start) state <= S_FETCH;
        S_FETCH:  if (bus.mem_ready) state <= S_DECODE;
        S_DECODE: begin
          case (bus.op)
            OP_LOAD, OP_STORE: state <= S_MEMADR;
            OP_RTYPE: begin
              if (dec_illegal) begin
                state     <= S_TRAP;
                illegal_q <= 1'b1;
              end else begin
                state <= S_EXECR;
              end
            end
            OP_ITYPE: begin
              if (dec_illegal) begin
                state     <= S_TRAP;
                illegal_q <= 1'b1;
              end else begin
                state <= S_EXECI;
              end
            end
            OP_BRANCH: state <= S_BEQ;
            OP_JAL:    state <= S_JAL;
            default: begin
              state     <= S_TRAP;
              illegal_q <= 1'b1;
            end
          endcase
        end
        S_MEMADR:   state <= (bus.op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (bus.mem_ready) state <= S_MEMWB;
        S_MEMWB:    state <= S_FETCH;
        S_MEMWRITE: if (bus.mem_ready) state <= S_FETCH;
        S_EXECR:    state <= S_ALUWB;
        S_EXECI:    state <= S_ALUWB;
        S_ALUWB:    state <= S_FETCH;
        S_BEQ:      state <= S_FETCH;
        S_JAL:      state <= S_ALUWB;
        S_TRAP:     state <= S_TRAP;
        default:    state <= S_TRAP;
      endcase
    end
  end

  // Per-state datapath controls; forced to their idle values while reset is held
  // so an in-flight store strobe drops without waiting for a clock.
  always_comb begin
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    imm_src     = IMM_I;
    alu_control = ALU_ADD;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          alu_src_b  = SRCB_FOUR;
          result_src = RES_ALURESULT;
          ir_write   = bus.mem_ready;
          pc_write   = bus.mem_ready;
        end
        S_DECODE: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_IMM;
          imm_src   = IMM_B;
        end
        S_MEMADR: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          imm_src   = (bus.op == OP_STORE) ? IMM_S : IMM_I;
        end
        S_MEMREAD: adr_src = 1'b1;
        S_MEMWB: begin
          result_src = RES_DATA;
          reg_write  = 1'b1;
        end
        S_MEMWRITE: begin
          adr_src   = 1'b1;
          mem_write = 1'b1;
        end
        S_EXECR: begin
          alu_src_a   = SRCA_RS1;
          alu_control = dec_ctrl;
        end
        S_EXECI: begin
          alu_src_a   = SRCA_RS1;
          alu_src_b   = SRCB_IMM;
          alu_control = dec_ctrl;
        end
        S_ALUWB: reg_write = 1'b1;
        S_BEQ: begin
          alu_src_a   = SRCA_RS1;
          alu_control = dec_ctrl;
          pc_write    = bus.Zero && (bus.funct3 == 3'b000);
        end
        S_JAL: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_FOUR;
          pc_write  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.PCWrite       = pc_write;
  assign bus.AdrSrc        = adr_src;
  assign bus.MemWrite      = mem_write;
  assign bus.IRWrite       = ir_write;
  assign bus.RegWrite      = reg_write;
  assign bus.ResultSrc     = result_src;
  assign bus.ALUSrcA       = alu_src_a;
  assign bus.ALUSrcB       = alu_src_b;
  assign bus.ImmSrc        = imm_src;
  assign bus.ALUControl    = alu_control;
  assign bus.illegal_instr = illegal_q;
  assign bus.mem_err       = mem_err_q;
  assign bus.state         = state;

`ifdef MC_CTRL_PERF_EN
  logic retire;

  // An instruction retires when a completing state hands control back to FETCH.
  always_comb begin
    retire = (state == S_MEMWB) || (state == S_ALUWB) || (state == S_BEQ) ||
             ((state == S_MEMWRITE) && bus.mem_ready);
  end

  // Free-running activity counters, wrapping at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state != S_HALT && state != S_TRAP) cycle_cnt <= cycle_cnt + 32'd1;
      if (retire) instret_cnt <= instret_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: default instance (dut0) and a HALT-start,
// MEM_TIMEOUT=4 instance (dut1).
module tb_mc_controller;
  import mc_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst0;
  logic rst1;
  always #5 clk = ~clk;

  mc_controller_if bus0 ();
  mc_controller_if bus1 ();

`ifdef MC_CTRL_PERF_EN
  logic [31:0] cyc0, ins0, cyc1, ins1;
`endif

  mc_controller dut0 (
    .clk   (clk),
    .reset (rst0),
    .bus   (bus0)
`ifdef MC_CTRL_PERF_EN
    ,
    .cycle_cnt   (cyc0),
    .instret_cnt (ins0)
`endif
  );

  mc_controller #(.RESET_STATE_FETCH(0), .MEM_TIMEOUT(4)) dut1 (
    .clk   (clk),
    .reset (rst1),
    .bus   (bus1)
`ifdef MC_CTRL_PERF_EN
    ,
    .cycle_cnt   (cyc1),
    .instret_cnt (ins1)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [31:0] st(input state_t s);
    return 32'(s);
  endfunction

  // Starts in a FETCH window of dut0; ends in the next FETCH window.
  task automatic alu_case(input string tag, input logic [6:0] op, input logic [2:0] f3,
                          input logic f7, input state_t exec_st);
    logic [3:0] exp_ctrl;
    bus0.op = op; bus0.funct3 = f3; bus0.funct7b5 = f7; bus0.mem_ready = 1'b1;
    settle();
    tick();                                   // DECODE
    tick();                                   // EXECR / EXECI
    exp_ctrl = exp_q.pop_front();
    check({tag, " state"}, st(bus0.state), st(exec_st));
    check({tag, " alu"}, 32'(bus0.ALUControl), 32'(exp_ctrl));
    tick();                                   // ALUWB
    check({tag, " wb"}, 32'(bus0.RegWrite), 32'd1);
    tick();                                   // FETCH
  endtask

  task automatic beq_case(input string tag, input logic [2:0] f3, input logic z,
                          input logic exp_pcw);
    bus0.op = 7'b1100011; bus0.funct3 = f3; bus0.mem_ready = 1'b1;
    settle();
    tick();                                   // DECODE
    tick();                                   // BEQ
    bus0.Zero = z;
    settle();
    check({tag, " state"}, st(bus0.state), st(S_BEQ));
    check({tag, " pcwrite"}, 32'(bus0.PCWrite), 32'(exp_pcw));
    check({tag, " alu"}, 32'(bus0.ALUControl), 32'h1);
    tick();
    bus0.Zero = 1'b0;
    check({tag, " back"}, st(bus0.state), st(S_FETCH));
  endtask

  task automatic trap_case(input string tag, input logic [6:0] op, input logic [2:0] f3);
    bus0.op = op; bus0.funct3 = f3; bus0.funct7b5 = 1'b0; bus0.mem_ready = 1'b1;
    settle();
    tick();                                   // DECODE
    check({tag, " decode"}, st(bus0.state), st(S_DECODE));
    tick();
    check({tag, " state"}, st(bus0.state), st(S_TRAP));
    check({tag, " flag"}, 32'(bus0.illegal_instr), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check({tag, " quiet"},
            32'({bus0.IRWrite, bus0.PCWrite, bus0.RegWrite, bus0.MemWrite}), 32'h0);
    end
    check({tag, " hold"}, st(bus0.state), st(S_TRAP));
    rst0 = 1'b1;
    settle();
    check({tag, " rst state"}, st(bus0.state), st(S_FETCH));
    check({tag, " rst flag"}, 32'(bus0.illegal_instr), 32'd0);
    tick();
    rst0 = 1'b0;
    settle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    rst0 = 1'b1; rst1 = 1'b1;
    bus0.start = 1'b0; bus0.op = 7'd0; bus0.funct3 = 3'd0; bus0.funct7b5 = 1'b0;
    bus0.Zero = 1'b0; bus0.mem_ready = 1'b1;
    bus1.start = 1'b0; bus1.op = 7'd0; bus1.funct3 = 3'd0; bus1.funct7b5 = 1'b0;
    bus1.Zero = 1'b0; bus1.mem_ready = 1'b0;
    #1;

    // Reset values while reset is held
    check("rst state", st(bus0.state), st(S_FETCH));
    check("rst irwrite", 32'(bus0.IRWrite), 32'd0);
    check("rst pcwrite", 32'(bus0.PCWrite), 32'd0);
    check("rst srcb", 32'(bus0.ALUSrcB), 32'd0);
    check("rst resultsrc", 32'(bus0.ResultSrc), 32'd0);
    check("rst aluctl", 32'(bus0.ALUControl), 32'd0);
    check("rst illegal", 32'(bus0.illegal_instr), 32'd0);
    check("rst1 state", st(bus1.state), st(S_HALT));
`ifdef MC_CTRL_PERF_EN
    check("rst cycle_cnt", cyc0, 32'd0);
    check("rst instret_cnt", ins0, 32'd0);
`endif
    tick();
    rst0 = 1'b0;

    // add x3,x1,x2 with mem_ready always high
    bus0.op = 7'b0110011; bus0.funct3 = 3'b000; bus0.funct7b5 = 1'b0;
    settle();
    check("add c1 state", st(bus0.state), st(S_FETCH));
    check("add c1 irwrite", 32'(bus0.IRWrite), 32'd1);
    check("add c1 pcwrite", 32'(bus0.PCWrite), 32'd1);
    check("add c1 srcb", 32'(bus0.ALUSrcB), 32'h2);
    check("add c1 resultsrc", 32'(bus0.ResultSrc), 32'h2);
    tick();
    check("add c2 state", st(bus0.state), st(S_DECODE));
    check("add c2 srca", 32'(bus0.ALUSrcA), 32'h1);
    check("add c2 srcb", 32'(bus0.ALUSrcB), 32'h1);
    check("add c2 immsrc", 32'(bus0.ImmSrc), 32'h2);
    check("add c2 regwrite", 32'(bus0.RegWrite), 32'd0);
    tick();
    check("add c3 state", st(bus0.state), st(S_EXECR));
    check("add c3 alu", 32'(bus0.ALUControl), 32'h0);
    check("add c3 srca", 32'(bus0.ALUSrcA), 32'h2);
    check("add c3 regwrite", 32'(bus0.RegWrite), 32'd0);
    tick();
    check("add c4 state", st(bus0.state), st(S_ALUWB));
    check("add c4 regwrite", 32'(bus0.RegWrite), 32'd1);
    tick();
    check("add c5 state", st(bus0.state), st(S_FETCH));
    check("add c5 regwrite", 32'(bus0.RegWrite), 32'd0);
`ifdef MC_CTRL_PERF_EN
    check("add cycle_cnt", cyc0, 32'd4);
    check("add instret_cnt", ins0, 32'd1);
`endif

    // ALU decode table
    exp_q = {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h0, 4'h8, 4'h2};
    alu_case("sub",  7'b0110011, 3'b000, 1'b1, S_EXECR);
    alu_case("and",  7'b0110011, 3'b111, 1'b0, S_EXECR);
    alu_case("or",   7'b0110011, 3'b110, 1'b0, S_EXECR);
    alu_case("xor",  7'b0110011, 3'b100, 1'b0, S_EXECR);
    alu_case("slt",  7'b0110011, 3'b010, 1'b0, S_EXECR);
    alu_case("sll",  7'b0110011, 3'b001, 1'b0, S_EXECR);
    alu_case("srl",  7'b0110011, 3'b101, 1'b0, S_EXECR);
    alu_case("sra",  7'b0110011, 3'b101, 1'b1, S_EXECR);
    alu_case("addi", 7'b0010011, 3'b000, 1'b1, S_EXECI);
    alu_case("srai", 7'b0010011, 3'b101, 1'b1, S_EXECI);
    alu_case("andi", 7'b0010011, 3'b111, 1'b0, S_EXECI);

    // lw with mem_ready low for 3 cycles in MEMREAD
    bus0.op = 7'b0000011; bus0.funct3 = 3'b010; bus0.mem_ready = 1'b1;
    settle();
    tick();
    tick();
    check("lw memadr state", st(bus0.state), st(S_MEMADR));
    check("lw memadr immsrc", 32'(bus0.ImmSrc), 32'h0);
    check("lw memadr srca", 32'(bus0.ALUSrcA), 32'h2);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      bus0.mem_ready = (i == 3);
      settle();
      if (bus0.state == S_MEMREAD) cnt++;
      check("lw adrsrc", 32'(bus0.AdrSrc), 32'd1);
      check("lw no regwrite", 32'(bus0.RegWrite), 32'd0);
    end
    check("lw memread cycles", 32'(cnt), 32'd4);
    tick();
    check("lw memwb state", st(bus0.state), st(S_MEMWB));
    check("lw memwb regwrite", 32'(bus0.RegWrite), 32'd1);
    check("lw memwb resultsrc", 32'(bus0.ResultSrc), 32'h1);
    tick();
    check("lw done state", st(bus0.state), st(S_FETCH));

    // sw with mem_ready low for 2 cycles
    bus0.op = 7'b0100011; bus0.funct3 = 3'b010; bus0.mem_ready = 1'b1;
    settle();
    tick();
    tick();
    check("sw memadr immsrc", 32'(bus0.ImmSrc), 32'h1);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      bus0.mem_ready = (i == 2);
      settle();
      if (bus0.MemWrite) cnt++;
    end
    tick();
    check("sw memwrite cycles", 32'(cnt), 32'd3);
    check("sw done state", st(bus0.state), st(S_FETCH));
    check("sw done memwrite", 32'(bus0.MemWrite), 32'd0);

    // Branches
    beq_case("beq taken", 3'b000, 1'b1, 1'b1);
    beq_case("beq not taken", 3'b000, 1'b0, 1'b0);
    beq_case("bne nop", 3'b001, 1'b1, 1'b0);

    // jal
    bus0.op = 7'b1101111; bus0.mem_ready = 1'b1;
    settle();
    tick();
    tick();
    check("jal state", st(bus0.state), st(S_JAL));
    check("jal pcwrite", 32'(bus0.PCWrite), 32'd1);
    check("jal srca", 32'(bus0.ALUSrcA), 32'h1);
    check("jal srcb", 32'(bus0.ALUSrcB), 32'h2);
    tick();
    check("jal wb", 32'(bus0.RegWrite), 32'd1);
    tick();
    check("jal done", st(bus0.state), st(S_FETCH));

    // Fetch stall without timeout
    bus0.mem_ready = 1'b0;
    settle();
    check("stall irwrite", 32'(bus0.IRWrite), 32'd0);
    for (int i = 0; i < 6; i++) tick();
    check("stall state", st(bus0.state), st(S_FETCH));
    check("stall no mem_err", 32'(bus0.mem_err), 32'd0);

    // Illegal opcode and illegal funct3
    trap_case("fence trap", 7'b0001111, 3'b000);
    trap_case("f3 011 trap", 7'b0110011, 3'b011);

    // dut1: HALT after reset, then fetch timeout
    tick();
    rst1 = 1'b0;
    bus1.mem_ready = 1'b1;
    settle();
    check("halt state", st(bus1.state), st(S_HALT));
    check("halt irwrite", 32'(bus1.IRWrite), 32'd0);
    tick();
    check("halt hold", st(bus1.state), st(S_HALT));
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    bus1.mem_ready = 1'b0;
    settle();
    check("to fetch", st(bus1.state), st(S_FETCH));
    for (int i = 0; i < 3; i++) tick();
    check("to c4 state", st(bus1.state), st(S_FETCH));
    check("to c4 mem_err", 32'(bus1.mem_err), 32'd0);
    tick();
    check("to trap state", st(bus1.state), st(S_TRAP));
    check("to mem_err", 32'(bus1.mem_err), 32'd1);
    tick();
    check("to sticky", 32'(bus1.mem_err), 32'd1);
    rst1 = 1'b1;
    settle();
    check("to rst state", st(bus1.state), st(S_HALT));
    check("to rst mem_err", 32'(bus1.mem_err), 32'd0);
    tick();
    rst1 = 1'b0;

    // dut1: reset during a store wait drops MemWrite at once
    bus1.start = 1'b1; bus1.op = 7'b0100011; bus1.funct3 = 3'b010; bus1.mem_ready = 1'b1;
    tick();                                   // FETCH
    bus1.start = 1'b0;
    tick();                                   // DECODE
    tick();                                   // MEMADR
    tick();                                   // MEMWRITE
    bus1.mem_ready = 1'b0;
    settle();
    check("abort memwrite on", 32'(bus1.MemWrite), 32'd1);
    rst1 = 1'b1;
    settle();
    check("abort memwrite off", 32'(bus1.MemWrite), 32'd0);
    check("abort state", st(bus1.state), st(S_HALT));
    tick();
    rst1 = 1'b0;

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
